// File: rtl/step_sequencer_pkg.sv
// Shared types for the step sequencer: FSM state and fault codes.
// Encodings are visible to the host through state_code / err_code.
package step_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_ACKLOW = 3'd2,
    ST_BRAKE  = 3'd3,
    ST_PAUSED = 3'd4,
    ST_ERR    = 3'd5
  } seq_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ESTOP   = 2'd1,
    ERR_DATA    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } seq_err_e;

  localparam logic [7:0] ALL_STOPPED = 8'hFF;

  function automatic logic is_busy(input seq_state_e s);
    return (s != ST_IDLE) && (s != ST_ERR);
  endfunction

endpackage

// File: rtl/step_sequencer_clk_divider.sv
// Free-running divider with synchronous clear and enable; emits a one-cycle
// tick on the cycle the count sits at DIV-1, so the first tick is DIV-1 cycles after clear.
module clk_divider #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic sclr,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (sclr || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/step_sequencer.sv
// Run-time sequencer: pulls one parser task per segment via step_req/step_ack,
// handles pause braking, soft stop, emergency stop and fault escalation.
//
//   state   | meaning
//   IDLE    | no program running, waiting for run
//   REQ     | step_req high, waiting for step_ack (ack timeout armed)
//   ACKLOW  | waiting for step_ack to drop, then pick next action
//   BRAKE   | braking command active until all axes report standstill
//   PAUSED  | standstill after pause, waiting for release or stop
//   ERR     | fault latched, outputs idle until err_clr
module step_sequencer
  import step_sequencer_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter int BRAKE_DIV   = 1000,
  parameter int ACK_TIMEOUT = 1048576
) (
  input  logic                 clk,
  input  logic                 sclr,
  input  logic                 run,
  input  logic                 pause,
  input  logic                 stop,
  input  logic                 estop,
  input  logic                 err_clr,
  input  logic                 task_empty,
  input  logic                 step_ack,
  input  logic [7:0]           stopped,
  input  logic [8:0]           error,
  output logic                 step_req,
  output logic                 braking,
  output logic                 brake_clk,
  output logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] step_cnt,
  output logic [2:0]           state_code,
  output logic [1:0]           err_code
);

  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  seq_state_e           state, state_nxt;
  seq_err_e             err_q, err_nxt;
  logic                 stop_pend, stop_pend_nxt;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_nxt;
  logic                 done_q, done_nxt;
  logic                 abort_q, abort_nxt;
  logic [TW-1:0]        tmo_q;
  logic                 all_stopped;
  logic                 stop_hit;

  assign all_stopped = (stopped == ALL_STOPPED);
  // A stop arriving on the deciding cycle must not be lost.
  assign stop_hit    = stop_pend || stop;

  always_ff @(posedge clk) begin
    if (sclr) begin
      state     <= ST_IDLE;
      err_q     <= ERR_NONE;
      stop_pend <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state     <= state_nxt;
      err_q     <= err_nxt;
      stop_pend <= stop_pend_nxt;
      cnt_q     <= cnt_nxt;
      done_q    <= done_nxt;
      abort_q   <= abort_nxt;
      tmo_q     <= (state == ST_REQ) ? tmo_q + TW'(1) : '0;
    end
  end

  always_comb begin
    state_nxt     = state;
    err_nxt       = err_q;
    stop_pend_nxt = stop_pend;
    cnt_nxt       = cnt_q;
    done_nxt      = done_q;
    abort_nxt     = 1'b0;

    if ((state != ST_ERR) && (estop || (error != '0))) begin
      state_nxt     = ST_ERR;
      abort_nxt     = 1'b1;
      err_nxt       = estop ? ERR_ESTOP : ERR_DATA;
      stop_pend_nxt = 1'b0;
    end else if ((state == ST_REQ) && (tmo_q == TMO_LAST)) begin
      state_nxt     = ST_ERR;
      abort_nxt     = 1'b1;
      err_nxt       = ERR_TIMEOUT;
      stop_pend_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) begin
            if (task_empty) begin
              done_nxt = 1'b1;
            end else begin
              state_nxt     = ST_REQ;
              cnt_nxt       = '0;
              done_nxt      = 1'b0;
              stop_pend_nxt = 1'b0;
            end
          end
        end
        ST_REQ: begin
          if (stop) stop_pend_nxt = 1'b1;
          if (step_ack) begin
            cnt_nxt   = cnt_q + CNT_WIDTH'(1);
            state_nxt = ST_ACKLOW;
          end
        end
        ST_ACKLOW: begin
          if (stop) stop_pend_nxt = 1'b1;
          if (!step_ack) begin
            if (stop_hit || pause) begin
              state_nxt = ST_BRAKE;
            end else if (task_empty && all_stopped) begin
              state_nxt = ST_IDLE;
              done_nxt  = 1'b1;
            end else if (!task_empty) begin
              state_nxt = ST_REQ;
            end
          end
        end
        ST_BRAKE: begin
          if (stop) stop_pend_nxt = 1'b1;
          if (all_stopped) begin
            if (stop_hit) begin
              state_nxt     = ST_IDLE;
              done_nxt      = 1'b0;
              stop_pend_nxt = 1'b0;
            end else begin
              state_nxt = ST_PAUSED;
            end
          end
        end
        ST_PAUSED: begin
          if (stop) begin
            state_nxt = ST_IDLE;
          end else if (!pause) begin
            if (task_empty) begin
              state_nxt = ST_IDLE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = ST_REQ;
            end
          end
        end
        ST_ERR: begin
          if (err_clr) begin
            state_nxt = ST_IDLE;
            err_nxt   = ERR_NONE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Divider runs only while braking and restarts from zero on every entry.
  clk_divider #(.DIV(BRAKE_DIV)) u_brake_div (
    .clk  (clk),
    .sclr (sclr),
    .clr  (state != ST_BRAKE),
    .en   (state == ST_BRAKE),
    .tick (brake_clk)
  );

  assign step_req   = (state == ST_REQ);
  assign braking    = (state == ST_BRAKE);
  assign abort      = abort_q;
  assign busy       = is_busy(state);
  assign done       = done_q;
  assign step_cnt   = cnt_q;
  assign state_code = state;
  assign err_code   = err_q;

endmodule
